vmem_cic: RTL and testbench
===========================

Name: vmem_cic

Overview:
- Time-multiplexed CIC decimator with run-time selectable decimation ratio.
- One adder/subtractor is shared across all stages. Integrator and comb state live in a small register memory indexed by stage.
- Sits after a low-rate sample source: input valid arrives sparsely, e.g. one strobe every 32 clocks. Output is a full-scale-normalised decimated stream.
- Differential delay M = 1. Every DEC_ARR entry must be a power of two.

Parameters:
- WIDTH_I, 16, signed input sample width.
- WIDTH_O, 17, signed output sample width; must be >= 2.
- STAGES, 10, number of integrator stages; an equal number of comb stages.
- MAX_DECIMATION, 16, largest ratio; sets internal width WIDTH_A = WIDTH_I + STAGES*clog2(MAX_DECIMATION), 56 by default.
- RATES, 4, number of selectable ratios.
- DEC_ARR, {2,4,8,16}, integer array[RATES] of ratios; each a power of two and <= MAX_DECIMATION.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- dec_sel_i  in  clog2(RATES)  index into DEC_ARR; R = DEC_ARR[dec_sel_i].
- data_i  in  WIDTH_I  signed input sample, valid while data_val_i = 1.
- data_val_i  in  1  input strobe, one cycle per sample.
- data_o  out  WIDTH_O  signed decimated output, held between strobes.
- data_val_o  out  1  one-cycle output strobe.
- error  out  1  sticky overrun flag.

Interface (already decided): reset rst_i, asynchronous, active-high; clock clk_i.

Behaviour:
- Reset: data_o = 0, data_val_o = 0, error = 0. All integrator/comb memory, decimation counter and sequencer are cleared; sequencer state = IDLE.
- Arithmetic: all internal arithmetic is WIDTH_A-bit two's complement with wrap-around. Modular wrap is intended and yields exact results.
- Integrator pass (state INT): on data_val_i in IDLE, data_i is sign-extended and latched. Then one stage per cycle for k = 0..STAGES-1: I[k] <= I[k] + (k == 0 ? x : I[k-1]new). Each stage uses the freshly updated value from the previous stage.
- Decimation count: after INT, the counter increments. If it reaches R-1, the counter is cleared and the sequencer goes to COMB; otherwise it returns to IDLE.
- Comb pass (state COMB): one stage per cycle for k = 0..STAGES-1, with c = stage input and D[k] = stored delay:
  - y = c - D[k];
  - D[k] <= c;
  - stage 0 input is I[STAGES-1].
- Output (state OUT): y_final is arithmetically shifted right by STAGES*log2(R) + WIDTH_I - WIDTH_O (floor), then truncated to WIDTH_O bits. If this shift is negative, shift left instead.
  - Effective DC gain = 2^(WIDTH_O - WIDTH_I), i.e. x2 with the defaults.
  - data_o is registered and data_val_o is pulsed for exactly one cycle.
- Latency: data_val_o is high exactly 2*STAGES + 2 cycles after the clock edge that samples data_val_i. That is 22 cycles with the defaults.
- Output rate: one data_val_o per R accepted inputs.
- Busy window: the block is busy from acceptance until its return to IDLE.
- Overrun: data_val_i = 1 while not IDLE drops that sample and sets error. error stays 1 until reset.
- Rate change: dec_sel_i is registered every cycle. When the registered value differs from the active one, the following happens on the next IDLE cycle before any sample is accepted:
  - all I/D memory is cleared;
  - the decimation counter is cleared;
  - the new R takes effect.
  - A data_val_i arriving in that same cycle is also accepted.
- After start or flush, the first STAGES outputs are transient; DC is exact from output STAGES+1 onward.

Decomposition:
- Package vmem_cic_pkg holds:
  - clog2 function;
  - WIDTH_A computation;
  - log2-of-ratio helper;
  - sequencer state enum {IDLE, INT, COMB, OUT}.
- One sub-module, cic_stage_mem: a STAGES-deep x WIDTH_A register file with async clear, single write port and combinational read. It is instantiated twice, once for integrator state I and once for comb delay D.
- Top level holds the sequencer, shared adder, decimation counter, scaler and output registers.

Test Plan:
- Reset: hold rst_i 1 cycle mid-stream -> data_o = 0, data_val_o = 0, error = 0 immediately; first output afterwards appears 22 cycles after the R-th strobe.
- DC, R = 16 (dec_sel_i = 3): data_i = 1000, data_val_i every 32 cycles -> data_val_o every 512 cycles, each pulse 22 cycles after a strobe; data_o = 2000 from output 11 onward.
- Negative full scale, R = 2 (dec_sel_i = 0): data_i = -32768 -> steady data_o = -65536 (17-bit minimum), no wrap.
- Sine: a 4096-phase, 16-bit sine source stepped by data_val_i, R = 16 -> output sine with period 256 output samples, peak ~65534 x sinc^10 droop (>= 65000), symmetric about 0.
- Overrun: data_val_i every 10 cycles -> error = 1 at the first strobe during busy, stays 1 until rst_i.
- Rate switch: dec_sel_i 3 -> 0 mid-stream with DC 1000 -> memory flushed; data_val_o then every 2 strobes; data_o = 2000 from the 11th post-switch output.

Source files
------------

// File: rtl/vmem_cic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vmem_cic_pkg
// Description : Shared types and elaboration helpers for the time-multiplexed
//               CIC decimator (width math, ratio log2, sequencer states).
// Revision    : 1.0 - initial release
// ============================================================================
package vmem_cic_pkg;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Internal accumulator width: enough headroom for the full CIC gain.
    function automatic int calc_width_a(input int width_i, input int stages,
                                        input int max_dec);
        return width_i + stages * clog2(max_dec);
    endfunction

    // Ratios are powers of two, so the ceiling log2 is exact.
    function automatic int log2_ratio(input int ratio);
        return clog2(ratio);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INT  = 2'd1,
        COMB = 2'd2,
        OUT  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/vmem_cic_stage_mem.sv
`default_nettype none
// ============================================================================
// Module      : cic_stage_mem
// Description : Per-stage state storage (DEPTH x WIDTH register file) with
//               asynchronous reset, synchronous bulk clear, one write port
//               and one combinational read port.
// Ports       : clk_i, rst_i      - clock, async active-high reset
//               i_clr             - synchronous clear of all entries
//               i_wr_en/i_wr_addr/i_wr_data - write port
//               i_rd_addr/o_rd_data         - combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
module cic_stage_mem #(
    parameter int DEPTH  = 10,
    parameter int WIDTH  = 56,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_mem[gi] <= '0;
                end else if (i_clr) begin
                    r_mem[gi] <= '0;
                end else if (i_wr_en && (i_wr_addr == ADDR_W'(gi))) begin
                    r_mem[gi] <= i_wr_data;
                end
            end
        end
    endgenerate

    // Mux loop instead of direct indexing keeps addresses >= DEPTH harmless.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_rd_addr == ADDR_W'(i)) begin
                o_rd_data = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vmem_cic.sv
`default_nettype none
// ============================================================================
// Module      : vmem_cic
// Description : Time-multiplexed CIC decimator, run-time selectable ratio.
//               One shared adder/subtractor walks the integrator stages, then
//               (every R-th sample) the comb stages, then scales the result.
// Ports       : clk_i, rst_i          - clock, async active-high reset
//               dec_sel_i             - ratio select, R = DEC_ARR[dec_sel_i]
//               data_i / data_val_i   - signed input sample and strobe
//               data_o / data_val_o   - decimated output and 1-cycle strobe
//               error                 - sticky overrun flag
// Revision    : 1.0 - initial release
// ============================================================================
module vmem_cic
    import vmem_cic_pkg::*;
#(
    parameter int WIDTH_I        = 16,
    parameter int WIDTH_O        = 17,
    parameter int STAGES         = 10,
    parameter int MAX_DECIMATION = 16,
    parameter int RATES          = 4,
    parameter int DEC_ARR [RATES] = '{2, 4, 8, 16},
    localparam int SEL_W         = (RATES > 1) ? clog2(RATES) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [SEL_W-1:0]          dec_sel_i,
    input  logic signed [WIDTH_I-1:0] data_i,
    input  logic                      data_val_i,
    output logic signed [WIDTH_O-1:0] data_o,
    output logic                      data_val_o,
    output logic                      error
);

    localparam int WIDTH_A = calc_width_a(WIDTH_I, STAGES, MAX_DECIMATION);
    localparam int STG_W   = (STAGES > 1) ? clog2(STAGES) : 1;
    localparam int CNT_W   = clog2(MAX_DECIMATION) + 1;
    localparam logic [STG_W-1:0] c_last_stage = STG_W'(STAGES - 1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [STG_W-1:0]    r_stage;
    logic [SEL_W-1:0]    r_sel_q;
    logic [SEL_W-1:0]    r_sel_act;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH_A-1:0]  r_x;
    logic [WIDTH_A-1:0]  r_acc;
    logic                r_error;
    logic                r_out_pend;
    logic [WIDTH_O-1:0]  r_scaled;
    logic [WIDTH_O-1:0]  r_data;
    logic                r_data_val;

    logic                w_flush;
    logic                w_accept;
    logic                w_overrun;
    logic                w_i_wr;
    logic                w_d_wr;
    logic                w_sub;
    logic                w_last;
    logic [WIDTH_A-1:0]  w_add_a;
    logic [WIDTH_A-1:0]  w_add_b;
    logic [WIDTH_A-1:0]  w_sum;
    logic [WIDTH_A-1:0]  w_i_rd;
    logic [WIDTH_A-1:0]  w_d_rd;
    logic [CNT_W-1:0]    w_ratio_m1;
    int                  w_shift;
    logic [WIDTH_O-1:0]  w_scaled;

    // Integrator state I[k]; written with the fresh sum of each stage.
    cic_stage_mem #(
        .DEPTH  (STAGES),
        .WIDTH  (WIDTH_A),
        .ADDR_W (STG_W)
    ) u_int_mem (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_clr     (w_flush),
        .i_wr_en   (w_i_wr),
        .i_wr_addr (r_stage),
        .i_wr_data (w_sum),
        .i_rd_addr (r_stage),
        .o_rd_data (w_i_rd)
    );

    // Comb delay D[k]; stores the stage input, which is held in r_acc.
    cic_stage_mem #(
        .DEPTH  (STAGES),
        .WIDTH  (WIDTH_A),
        .ADDR_W (STG_W)
    ) u_comb_mem (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_clr     (w_flush),
        .i_wr_en   (w_d_wr),
        .i_wr_addr (r_stage),
        .i_wr_data (r_acc),
        .i_rd_addr (r_stage),
        .o_rd_data (w_d_rd)
    );

    // Active ratio and output shift, decoded from the active select.
    always_comb begin
        w_ratio_m1 = '0;
        w_shift    = 0;
        for (int i = 0; i < RATES; i++) begin
            if (r_sel_act == SEL_W'(i)) begin
                w_ratio_m1 = CNT_W'(DEC_ARR[i] - 1);
                w_shift    = STAGES * log2_ratio(DEC_ARR[i]) + WIDTH_I - WIDTH_O;
            end
        end
    end

    // Floor scaling: arithmetic right shift; left shift if the gain is short.
    always_comb begin
        if (w_shift >= 0) begin
            w_scaled = WIDTH_O'($signed(r_acc) >>> w_shift);
        end else begin
            w_scaled = WIDTH_O'(r_acc << (-w_shift));
        end
    end

    // Shared adder/subtractor: a + b or a - b (two's complement, wraps).
    always_comb begin
        w_sum = w_add_a + (w_sub ? ~w_add_b : w_add_b)
              + {{(WIDTH_A-1){1'b0}}, w_sub};
    end

    assign w_last = (r_stage == c_last_stage);

    // Sequencer next state and datapath control.
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_accept    = 1'b0;
        w_i_wr      = 1'b0;
        w_d_wr      = 1'b0;
        w_sub       = 1'b0;
        w_add_a     = r_acc;
        w_add_b     = w_d_rd;
        w_overrun   = data_val_i && (r_state != IDLE);
        case (r_state)
            IDLE: begin
                // A pending rate change flushes before (and alongside) acceptance.
                w_flush = (r_sel_q != r_sel_act);
                if (data_val_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = INT;
                end
            end
            INT: begin
                w_i_wr  = 1'b1;
                w_add_a = w_i_rd;
                // r_acc holds the freshly updated previous-stage value.
                w_add_b = (r_stage == '0) ? r_x : r_acc;
                if (w_last) begin
                    w_state_nxt = (r_cnt == w_ratio_m1) ? COMB : IDLE;
                end
            end
            COMB: begin
                // Comb stage 0 input is the last integrator, still in r_acc.
                w_d_wr  = 1'b1;
                w_sub   = 1'b1;
                w_add_a = r_acc;
                w_add_b = w_d_rd;
                if (w_last) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_stage    <= '0;
            r_sel_q    <= '0;
            r_sel_act  <= '0;
            r_cnt      <= '0;
            r_x        <= '0;
            r_acc      <= '0;
            r_error    <= 1'b0;
            r_out_pend <= 1'b0;
            r_scaled   <= '0;
            r_data     <= '0;
            r_data_val <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel_q    <= dec_sel_i;
            r_out_pend <= (r_state == OUT);
            r_data_val <= r_out_pend;

            if (w_flush) begin
                r_sel_act <= r_sel_q;
                r_cnt     <= '0;
            end

            if (w_accept) begin
                r_x <= {{(WIDTH_A-WIDTH_I){data_i[WIDTH_I-1]}}, data_i};
            end

            if ((r_state == INT) || (r_state == COMB)) begin
                r_acc   <= w_sum;
                r_stage <= w_last ? '0 : r_stage + 1'b1;
            end

            if ((r_state == INT) && w_last) begin
                r_cnt <= (r_cnt == w_ratio_m1) ? '0 : r_cnt + 1'b1;
            end

            if (r_state == OUT) begin
                r_scaled <= w_scaled;
            end

            if (r_out_pend) begin
                r_data <= r_scaled;
            end

            if (w_overrun) begin
                r_error <= 1'b1;
            end
        end
    end

    assign data_o     = r_data;
    assign data_val_o = r_data_val;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_vmem_cic.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmem_cic
// Description : Self-checking bench for vmem_cic. Reference model treats the
//               decimator as its equivalent FIR (boxcar of length R convolved
//               STAGES times) evaluated on every R-th input since flush.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vmem_cic;

    localparam int WI   = 16;
    localparam int WO   = 17;
    localparam int N    = 10;
    localparam int HMAX = N * 15 + 1;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic [1:0]            dec_sel_i = 2'd0;
    logic signed [WI-1:0]  data_i = '0;
    logic                  data_val_i = 1'b0;
    logic signed [WO-1:0]  data_o;
    logic                  data_val_o;
    logic                  error;

    vmem_cic dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .dec_sel_i  (dec_sel_i),
        .data_i     (data_i),
        .data_val_i (data_val_i),
        .data_o     (data_o),
        .data_val_o (data_val_o),
        .error      (error)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    longint hcoef [HMAX];
    int     hlen;
    longint hist [$];
    int     m_r;
    int     m_shift;
    int     cur_sel;
    int     n_out;

    typedef struct {
        int sel;
        int x;
        int steady;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int ratio_of(input int sel);
        return 2 << sel;
    endfunction

    // Impulse response of STAGES cascaded length-R moving sums.
    task automatic model_set_rate(input int sel);
        longint tmp [HMAX];
        int lg;
        m_r = ratio_of(sel);
        lg = sel + 1;
        m_shift = N * lg + WI - WO;
        for (int i = 0; i < HMAX; i++) hcoef[i] = 0;
        hcoef[0] = 1;
        hlen = 1;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < hlen + m_r - 1; i++) begin
                tmp[i] = 0;
                for (int j = 0; j < m_r; j++) begin
                    if (i - j >= 0 && i - j < hlen) tmp[i] += hcoef[i-j];
                end
            end
            hlen = hlen + m_r - 1;
            for (int i = 0; i < hlen; i++) hcoef[i] = tmp[i];
        end
        hist.delete();
    endtask

    function automatic longint model_out();
        longint acc;
        longint sh;
        logic signed [WO-1:0] t;
        int n;
        acc = 0;
        n = hist.size();
        for (int j = 0; j < hlen; j++) begin
            if (j < n) acc += hcoef[j] * hist[n-1-j];
        end
        sh = (m_shift >= 0) ? (acc >>> m_shift) : (acc <<< (-m_shift));
        t = sh[WO-1:0];
        return longint'(t);
    endfunction

    // Drive one strobe, then watch gap cycles. Entered and left at a negedge.
    task automatic strobe(input logic signed [WI-1:0] x, input int gap, input bit chk);
        bit     exp_out;
        longint exp_val;
        int     pulses;
        int     pulse_at;
        longint got;
        exp_out = 1'b0;
        exp_val = 0;
        if (chk) begin
            hist.push_back(longint'(x));
            if (hist.size() % m_r == 0) begin
                exp_out = 1'b1;
                exp_val = model_out();
            end
        end
        data_i = x;
        data_val_i = 1'b1;
        @(posedge clk_i);
        pulses = 0;
        pulse_at = -1;
        got = 0;
        for (int c = 0; c < gap; c++) begin
            @(negedge clk_i);
            if (c == 0) data_val_i = 1'b0;
            if (data_val_o) begin
                pulses++;
                if (pulse_at < 0) begin
                    pulse_at = c;
                    got = longint'(data_o);
                end
            end
        end
        if (chk) begin
            if (exp_out) begin
                check("out_latency", pulse_at, 22);
                check("out_pulse_count", pulses, 1);
                check("out_value", got, exp_val);
                n_out++;
            end else begin
                check("no_out_pulse", pulses, 0);
            end
        end
    endtask

    task automatic set_rate(input int sel, input int settle);
        dec_sel_i = 2'(sel);
        if (sel != cur_sel) model_set_rate(sel);
        cur_sel = sel;
        repeat (settle) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("rst_data_o", longint'(data_o), 0);
        check("rst_data_val_o", longint'(data_val_o), 0);
        check("rst_error", longint'(error), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        model_set_rate(cur_sel);
    endtask

    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3,   1000,   2000};
        vecs[1] = '{0, -32768, -65536};
        vecs[2] = '{1,  32767,  65534};
        vecs[3] = '{2,     -1,     -2};
        vecs[4] = '{0,  12345,  24690};

        cur_sel = 0;
        model_set_rate(0);
        do_reset();

        // DC table: each row flushes to a new ratio and runs to steady state.
        for (int v = 0; v < 5; v++) begin
            set_rate(vecs[v].sel, 2);
            n_out = 0;
            while (n_out < N + 2) strobe(WI'(vecs[v].x), 32, 1'b1);
            check("dc_steady", longint'(data_o), longint'(vecs[v].steady));
        end

        // Rate switch 3 -> 0 mid-stream; first post-switch sample lands on the
        // flush cycle and must still be accepted.
        set_rate(3, 2);
        for (int i = 0; i < 20; i++) strobe(16'sd1000, 32, 1'b1);
        set_rate(0, 1);
        n_out = 0;
        while (n_out < N + 1) strobe(16'sd1000, 32, 1'b1);
        check("switch_steady", longint'(data_o), 2000);

        // Random samples, ratios and gaps.
        for (int seg = 0; seg < 3; seg++) begin
            int sel;
            sel = (cur_sel + 1 + int'($urandom_range(0, 2))) % 4;
            set_rate(sel, 2);
            for (int i = 0; i < ratio_of(sel) * 6; i++) begin
                strobe(WI'($urandom), int'($urandom_range(23, 40)), 1'b1);
            end
        end

        // Overrun: strobes every 10 cycles hit the busy window.
        set_rate(3, 2);
        strobe(16'sd1000, 10, 1'b0);
        check("overrun_before", longint'(error), 0);
        strobe(16'sd1000, 10, 1'b0);
        check("overrun_set", longint'(error), 1);
        for (int i = 0; i < 3; i++) strobe(16'sd1000, 10, 1'b0);
        repeat (40) @(negedge clk_i);
        check("overrun_sticky", longint'(error), 1);

        // Reset while busy, then a fresh run to the first output.
        data_i = 16'sd1000;
        data_val_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        data_val_i = 1'b0;
        repeat (4) @(negedge clk_i);
        do_reset();
        n_out = 0;
        for (int i = 0; i < 16; i++) strobe(16'sd1000, 32, 1'b1);
        check("post_reset_outputs", n_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
